// File: rtl/ds1822_pkg.sv
// rtl/ds1822_pkg.sv - shared constants and FSM state type for the DS1822 readout scanner
package ds1822_pkg;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_STALE   = 3'd1;
    localparam logic [2:0] ST_NO_CHIP = 3'd2;
    localparam logic [2:0] ST_SHORT   = 3'd3;
    localparam logic [2:0] ST_SP_CRC  = 3'd4;
    localparam logic [2:0] ST_ROM_CRC = 3'd5;
    localparam logic [2:0] ST_MARKER  = 3'd6;

    localparam logic [7:0] MK_FD = 8'hfd;
    localparam logic [7:0] MK_CC = 8'hcc;
    localparam logic [7:0] MK_BE = 8'hbe;
    localparam logic [7:0] MK_33 = 8'h33;

    localparam logic [4:0] A_B2  = 5'd2;
    localparam logic [4:0] A_B3  = 5'd3;
    localparam logic [4:0] A_B4  = 5'd4;
    localparam logic [4:0] A_B5  = 5'd5;
    localparam logic [4:0] A_B6  = 5'd6;
    localparam logic [4:0] A_B13 = 5'd13;
    localparam logic [4:0] A_B18 = 5'd18;
    localparam logic [4:0] A_B19 = 5'd19;
    localparam logic [4:0] A_B20 = 5'd20;
    localparam logic [4:0] A_B27 = 5'd27;
    localparam logic [4:0] A_B29 = 5'd29;
    localparam logic [4:0] A_B30 = 5'd30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPT,
        S_CRC,
        S_NEXT,
        S_CHECK,
        S_PUBLISH
    } state_e;

endpackage

// File: rtl/onewire_crc8.sv
// rtl/onewire_crc8.sv - bit-serial Dallas CRC-8 (reflected 0x8C), one bit per clock
module onewire_crc8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic [7:0] crc_o,
    output logic       busy_o,
    output logic       done_o
);
    logic [7:0] crc_q;
    logic [7:0] sh_q;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic       fb;

    assign fb     = crc_q[0] ^ sh_q[0];
    assign crc_o  = crc_q;
    assign busy_o = busy_q;
    // done coincides with the final bit so a byte costs exactly 8 cycles
    assign done_o = busy_q && (cnt_q == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q  <= 8'h00;
            sh_q   <= 8'h00;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else if (clear_i) begin
            crc_q  <= 8'h00;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            sh_q   <= byte_i;
            cnt_q  <= 3'd0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            crc_q  <= {1'b0, crc_q[7:1]} ^ (fb ? 8'h8c : 8'h00);
            sh_q   <= {1'b0, sh_q[7:1]};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ds1822_reader.sv
// rtl/ds1822_reader.sv - periodic scanner of the DS1822 driver readout port with CRC and status publish
module ds1822_reader
    import ds1822_pkg::*;
#(
    parameter int POLL_CNT = 50000,
    parameter int RD_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    output logic [4:0]  address_o,
    input  logic [7:0]  result_i,
    output logic [15:0] temp_o,
    output logic        temp_valid_o,
    output logic [63:0] serial_o,
    output logic        rom_valid_o,
    output logic [2:0]  status_o,
    output logic        update_o
);
    state_e      state_q;
    logic [16:0] timer_q;
    logic        pend_q;
    logic [4:0]  addr_q;
    logic [3:0]  wait_q;
    logic [7:0]  b2_q, b3_q, b4_q, b5_q, b6_q, b18_q, b19_q, b29_q, b30_q;
    logic [63:0] rom_q;
    logic [2:0]  chk_q;
    logic [2:0]  status_d;
    logic [7:0]  sp_crc, rom_crc;
    logic        sp_busy, rom_busy, sp_done, rom_done;
    logic        in_sp, in_rom, timer_wrap, crc_clear;

    assign timer_wrap = (timer_q == 17'(POLL_CNT - 1));
    assign in_sp      = (addr_q >= A_B5) && (addr_q <= A_B13);
    assign in_rom     = (addr_q >= A_B20) && (addr_q <= A_B27);
    assign crc_clear  = (state_q == S_IDLE);

    onewire_crc8 u_sp_crc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (crc_clear),
        .start_i ((state_q == S_CAPT) && in_sp),
        .byte_i  (result_i),
        .crc_o   (sp_crc),
        .busy_o  (sp_busy),
        .done_o  (sp_done)
    );

    onewire_crc8 u_rom_crc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (crc_clear),
        .start_i ((state_q == S_CAPT) && in_rom),
        .byte_i  (result_i),
        .crc_o   (rom_crc),
        .busy_o  (rom_busy),
        .done_o  (rom_done)
    );

    always_comb begin
        status_d = ST_OK;
        if (b3_q == 8'hff && b4_q == 8'hff)                                   status_d = ST_SHORT;
        else if (b4_q == 8'h00)                                               status_d = ST_STALE;
        else if (b2_q != MK_FD || b18_q != MK_FD || b29_q != MK_FD)           status_d = ST_NO_CHIP;
        else if (b3_q != MK_CC || b4_q != MK_BE || b19_q != MK_33 || b30_q != MK_CC)
                                                                              status_d = ST_MARKER;
        else if (sp_crc != 8'h00)                                             status_d = ST_SP_CRC;
        else if (rom_crc != 8'h00)                                            status_d = ST_ROM_CRC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pend_q       <= 1'b0;
            addr_q       <= '0;
            wait_q       <= '0;
            {b2_q, b3_q, b4_q, b5_q, b6_q} <= '0;
            {b18_q, b19_q, b29_q, b30_q}   <= '0;
            rom_q        <= '0;
            chk_q        <= ST_STALE;
            address_o    <= '0;
            temp_o       <= '0;
            temp_valid_o <= 1'b0;
            serial_o     <= '0;
            rom_valid_o  <= 1'b0;
            status_o     <= ST_STALE;
            update_o     <= 1'b0;
        end else if (!enable_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pend_q    <= 1'b0;
            address_o <= '0;
            update_o  <= 1'b0;
        end else begin
            update_o <= 1'b0;
            timer_q  <= timer_wrap ? '0 : timer_q + 17'd1;
            // wraps landing during a scan are dropped rather than queued
            if (timer_wrap && state_q == S_IDLE) pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    address_o <= '0;
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        addr_q  <= '0;
                        wait_q  <= '0;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (wait_q == 4'(RD_LAT)) state_q <= S_CAPT;
                    else                      wait_q  <= wait_q + 4'd1;
                end
                S_CAPT: begin
                    case (addr_q)
                        A_B2:    b2_q  <= result_i;
                        A_B3:    b3_q  <= result_i;
                        A_B4:    b4_q  <= result_i;
                        A_B5:    b5_q  <= result_i;
                        A_B6:    b6_q  <= result_i;
                        A_B18:   b18_q <= result_i;
                        A_B19:   b19_q <= result_i;
                        A_B29:   b29_q <= result_i;
                        A_B30:   b30_q <= result_i;
                        default: ;
                    endcase
                    // ROM bytes arrive in order 20..27, so shifting in leaves byte 20 in the low octet
                    if (in_rom) rom_q <= {result_i, rom_q[63:8]};
                    state_q <= (in_sp || in_rom) ? S_CRC : S_NEXT;
                end
                S_CRC: begin
                    if (sp_done || rom_done) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (addr_q == A_B30) begin
                        state_q <= S_CHECK;
                    end else begin
                        addr_q    <= addr_q + 5'd1;
                        address_o <= addr_q + 5'd1;
                        wait_q    <= '0;
                        state_q   <= S_SETTLE;
                    end
                end
                S_CHECK: begin
                    if (!(sp_busy || rom_busy)) begin
                        chk_q   <= status_d;
                        state_q <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    status_o  <= chk_q;
                    update_o  <= 1'b1;
                    address_o <= '0;
                    state_q   <= S_IDLE;
                    if (chk_q == ST_OK || chk_q == ST_ROM_CRC) begin
                        temp_o       <= {b6_q, b5_q};
                        temp_valid_o <= 1'b1;
                    end
                    if (chk_q == ST_OK || chk_q == ST_SP_CRC) begin
                        serial_o    <= rom_q;
                        rom_valid_o <= 1'b1;
                    end
                    if (chk_q == ST_SHORT || chk_q == ST_NO_CHIP) begin
                        temp_valid_o <= 1'b0;
                        rom_valid_o  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ds1822_reader.md
Name: ds1822_reader

Overview:
- Downstream consumer of the DS1822 1-Wire driver's address/result readout port.
- Periodically scans driver addresses 0..30 and classifies the bus condition from the marker bytes.
- Checks Dallas CRC-8 over the scratchpad and the ROM serial number.
- Publishes the latched temperature word, 64-bit serial and a status code for register-bank readout.

Parameters:
- POLL_CNT, 50000: clk cycles between scan starts (1 ms at 50 MHz); must exceed one scan duration.
- RD_LAT, 2: clk cycles from address change to valid result (driver RAM register plus consistency flag).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  high = scanning allowed
- address  out  5  driver readout address
- result  in  8  driver readout data
- temp  out  16  raw temperature, {byte6, byte5}
- temp_valid  out  1  temp holds a CRC-verified reading
- serial  out  64  ROM bytes 27..20; byte20 (family code) in [7:0]
- rom_valid  out  1  serial holds a CRC-verified ROM
- status  out  3  result of last completed scan
- update  out  1  one-cycle strobe at each scan completion

Behaviour:
- Reset values: address=0, temp=0, serial=0, temp_valid=0, rom_valid=0, status=1 (STALE), update=0, poll timer=0, FSM=IDLE.
- Poll timer: 17-bit, free-running while enable=1, wraps at POLL_CNT-1. Each wrap raises a pending-scan flag. A wrap while a scan is in progress is dropped, not queued.
- FSM states:
  - IDLE: address=0. On pending flag, go to SETTLE with addr_ctr=0.
  - SETTLE: hold address=addr_ctr for RD_LAT+1 cycles, then CAPT.
  - CAPT: register result into the byte slot for addr_ctr.
    - addr_ctr 5..13: SP CRC accumulates the byte; go to CRC.
    - addr_ctr 20..27: ROM CRC accumulates the byte; go to CRC.
    - otherwise go to NEXT.
  - CRC: wait for the sub-module done pulse (8 cycles), then NEXT.
  - NEXT: if addr_ctr==30 go to CHECK, else addr_ctr+1 and go to SETTLE.
  - CHECK: compute status (one cycle), then PUBLISH.
  - PUBLISH: update outputs and pulse update; return to IDLE.
- Address 0 is always read first. Per-address dwell is at most RD_LAT+11 cycles, well under the driver's 655 us limit.
- Stored bytes: b2, b3, b4, b5, b6, b18, b19, b29, b30, b20..b27. Other bytes are read and discarded.
- Status, first match wins:
  - 3 SHORT: b3==ff and b4==ff
  - 1 STALE: b4==00 (driver mid-conversion; all zeros)
  - 2 NO_CHIP: b2!=fd or b18!=fd or b29!=fd
  - 6 MARKER: b3!=cc, b4!=be, b19!=33 or b30!=cc
  - 4 SP_CRC: scratchpad CRC residue !=0 (9 bytes including CRC byte 13)
  - 5 ROM_CRC: ROM CRC residue !=0
  - 0 OK
- Publish rules:
  - temp/temp_valid=1 loaded when status is OK or ROM_CRC.
  - serial/rom_valid=1 loaded when status is OK or SP_CRC.
  - STALE or MARKER: temp, serial and valid flags hold their previous values.
  - SHORT or NO_CHIP: temp_valid and rom_valid are cleared; the data words hold.
- CRC: Dallas polynomial x^8+x^5+x^4+1, reflected 0x8C, LSB-first, init 00. Two accumulators are cleared at scan start.
- enable=0 mid-scan: abort to IDLE at the next clock with address=0 and the pending flag cleared. Outputs hold; no update pulse. The poll timer clears and holds.
- rst mid-scan: everything returns to reset values immediately.

Decomposition:
- Shared package ds1822_pkg:
  - status code constants
  - marker byte constants: fd, cc, be, 33
  - address constants 2, 3, 4, 5, 13, 18, 19, 20, 27, 29, 30
- Sub-module onewire_crc8:
  - bit-serial; inputs clk, rst, clear, start, byte[7:0]; outputs crc[7:0], busy, done.
  - processes one bit per clock (8 cycles per byte).
  - instantiated twice (scratchpad, ROM), or once with a select; implementer's choice.

Test Plan:
- Driver model (31-byte memory, RD_LAT=2) loaded with the nominal image: b2=fd, cc, be, scratchpad 50 05 4b 46 7f ff 0c 10 1c, b18=fd, 33, ROM 28 a2 d9 84 00 00 02 xx with valid CRC, b29=fd, cc. Required: status=0, temp=0550, temp_valid=1, serial[7:0]=28, one update pulse.
- All-zero image -> status=1; temp and serial unchanged from the prior scan; valid flags unchanged.
- b2=b18=b29=ff, scratchpad and ROM all zero -> status=2, temp_valid=0, rom_valid=0.
- All-ff image -> status=3, both valid flags cleared.
- Nominal image with scratchpad byte 13 corrupted -> status=4, temp held, serial updated, rom_valid=1.
- Deassert enable at addr_ctr=10 -> address=0 next cycle, no update pulse, outputs unchanged. Re-enable -> full scan after POLL_CNT cycles. Assert rst mid-scan -> all reset values immediately.
